// File: rtl/dpa_mp_pkg.sv
// Shared types and defaults for the multi-precision add/subtract sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dpa_mp_pkg;

    localparam int DEFAULT_WORD_W    = 64;
    localparam int DEFAULT_NUM_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dpa_mp_sequencer_dpa1.sv
// Single-word adder: a + b + cin with carry, zero, negative and signed overflow flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
module DPA1 #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         signed_en,
    output logic [N-1:0] final_sum,
    output logic         cout,
    output logic         zero_flag,
    output logic         overflow_flag,
    output logic         negative_flag
);

    logic [N:0] full_sum;

    // One extra bit captures the carry out of the word.
    assign full_sum  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign final_sum = full_sum[N-1:0];
    assign cout      = full_sum[N];

    assign zero_flag     = ~|final_sum;
    assign negative_flag = final_sum[N-1];
    // Signed overflow: like-signed operands produced an opposite-signed sum.
    // Only meaningful on the word that holds the sign, hence the enable.
    assign overflow_flag = signed_en & (a[N-1] == b[N-1]) & (final_sum[N-1] != a[N-1]);

endmodule

// File: rtl/dpa_mp_sequencer.sv
// Multi-precision add/subtract: streams NUM_WORDS words LSW-first through one DPA1 (optional abort: DPA_MP_ABORT_EN).
// Latency: NUM_WORDS cycles from accept to out_valid; one request in flight at a time.
// Backpressure: in_ready low outside IDLE; result held in DONE until out_ready.
module dpa_mp_sequencer
    import dpa_mp_pkg::*;
#(
    parameter int WORD_W    = DEFAULT_WORD_W,
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] op_a,
    input  logic [WORD_W*NUM_WORDS-1:0] op_b,
    input  logic                        sub,
    input  logic                        signed_en,
`ifdef DPA_MP_ABORT_EN
    input  logic                        abort,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] result,
    output logic                        cout,
    output logic                        negative_flag,
    output logic                        overflow_flag,
    output logic                        zero_flag
);

    localparam int                IDX_W    = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t state_q;
    state_t state_d;

    logic [WORD_W-1:0] op_a_w   [NUM_WORDS];
    logic [WORD_W-1:0] op_b_w   [NUM_WORDS];
    logic [WORD_W-1:0] a_q      [NUM_WORDS];
    logic [WORD_W-1:0] b_q      [NUM_WORDS];
    logic [WORD_W-1:0] work_q   [NUM_WORDS];
    logic [WORD_W-1:0] result_q [NUM_WORDS];

    logic             se_q;
    logic             carry_q;
    logic             zero_acc_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_word;
    logic             abort_i;

    logic             cout_q;
    logic             neg_q;
    logic             ovf_q;
    logic             zero_q;

    logic [WORD_W-1:0] dpa_a;
    logic [WORD_W-1:0] dpa_b;
    logic              dpa_se;
    logic [WORD_W-1:0] dpa_sum;
    logic              dpa_cout;
    logic              dpa_zero;
    logic              dpa_ovf;
    logic              dpa_neg;

`ifdef DPA_MP_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Word views of the wide operand inputs and the registered result.
    for (genvar g = 0; g < NUM_WORDS; g++) begin : gen_words
        assign op_a_w[g]                     = op_a[g*WORD_W +: WORD_W];
        assign op_b_w[g]                     = op_b[g*WORD_W +: WORD_W];
        assign result[g*WORD_W +: WORD_W]    = result_q[g];
    end

    assign last_word = (idx_q == LAST_IDX);

    // Word mux feeding the adder; only the top word sees the signed enable.
    always_comb begin
        dpa_a  = a_q[idx_q];
        dpa_b  = b_q[idx_q];
        dpa_se = last_word & se_q;
    end

    DPA1 #(.N(WORD_W)) u_dpa1 (
        .a             (dpa_a),
        .b             (dpa_b),
        .cin           (carry_q),
        .signed_en     (dpa_se),
        .final_sum     (dpa_sum),
        .cout          (dpa_cout),
        .zero_flag     (dpa_zero),
        .overflow_flag (dpa_ovf),
        .negative_flag (dpa_neg)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; abort wins over out_ready.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (abort_i || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch and per-word carry/zero/index sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                work_q[i] <= '0;
            end
            se_q       <= 1'b0;
            carry_q    <= 1'b0;
            zero_acc_q <= 1'b0;
            idx_q      <= '0;
        end else if (state_q == IDLE) begin
            if (in_valid) begin
                // Subtraction is A + ~B + 1: invert B here, seed the carry below.
                for (int i = 0; i < NUM_WORDS; i++) begin
                    a_q[i] <= op_a_w[i];
                    b_q[i] <= op_b_w[i] ^ {WORD_W{sub}};
                end
                se_q       <= signed_en;
                carry_q    <= sub;
                zero_acc_q <= 1'b1;
                idx_q      <= '0;
            end
        end else if (state_q == RUN && !abort_i) begin
            work_q[idx_q] <= dpa_sum;
            carry_q       <= dpa_cout;
            zero_acc_q    <= zero_acc_q & dpa_zero;
            if (!last_word) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Visible result registers: loaded only on entry to DONE, cleared on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                result_q[i] <= '0;
            end
            cout_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (abort_i && state_q != IDLE) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                result_q[i] <= '0;
            end
            cout_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state_q == RUN && last_word) begin
            // Lower words come from the work buffer, the top word straight from the adder.
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
                result_q[i] <= work_q[i];
            end
            result_q[NUM_WORDS-1] <= dpa_sum;
            cout_q <= dpa_cout;
            neg_q  <= dpa_neg;
            ovf_q  <= dpa_ovf;
            zero_q <= zero_acc_q & dpa_zero;
        end
    end

    assign cout          = cout_q;
    assign negative_flag = neg_q;
    assign overflow_flag = ovf_q;
    assign zero_flag     = zero_q;

endmodule

// File: tb/tb_dpa_mp_sequencer.sv
module tb_dpa_mp_sequencer;

    localparam int WW = 8;
    localparam int NW = 4;
    localparam int TW = WW * NW;

    typedef struct {
        logic [TW-1:0] res;
        logic          c;
        logic          n;
        logic          o;
        logic          z;
    } res_t;

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          s;
        logic          se;
        res_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] op_a;
    logic [TW-1:0] op_b;
    logic          sub;
    logic          signed_en;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] result;
    logic          cout;
    logic          negative_flag;
    logic          overflow_flag;
    logic          zero_flag;
`ifdef DPA_MP_ABORT_EN
    logic          abort;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpa_mp_sequencer #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .sub           (sub),
        .signed_en     (signed_en),
`ifdef DPA_MP_ABORT_EN
        .abort         (abort),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .cout          (cout),
        .negative_flag (negative_flag),
        .overflow_flag (overflow_flag),
        .zero_flag     (zero_flag)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_outs(input string tag, input res_t e);
        check({tag, ".result"}, 64'(result), 64'(e.res));
        check({tag, ".cout"}, 64'(cout), 64'(e.c));
        check({tag, ".negative"}, 64'(negative_flag), 64'(e.n));
        check({tag, ".overflow"}, 64'(overflow_flag), 64'(e.o));
        check({tag, ".zero"}, 64'(zero_flag), 64'(e.z));
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".result"}, 64'(result), 64'd0);
        check({tag, ".flags"}, 64'({cout, negative_flag, overflow_flag, zero_flag}), 64'd0);
    endtask

    // Reference: exact integer arithmetic, then reduced modulo 2^TW.
    function automatic res_t model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                   input logic s, input logic se);
        res_t   r;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint exact_s = s ? sa - sb : sa + sb;
        longint exact_u = s ? ua - ub : ua + ub;
        r.res = exact_u[TW-1:0];
        r.c   = s ? (ua >= ub) : (exact_u >= (64'sd1 <<< TW));
        r.n   = r.res[TW-1];
        r.z   = (r.res == '0);
        r.o   = se && ((exact_s > ((64'sd1 <<< (TW-1)) - 1)) || (exact_s < -(64'sd1 <<< (TW-1))));
        return r;
    endfunction

    function automatic vec_t mk(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s,
                                input logic se, input logic [TW-1:0] res, input logic c,
                                input logic n, input logic o, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.se = se;
        v.exp.res = res; v.exp.c = c; v.exp.n = n; v.exp.o = o; v.exp.z = z;
        return v;
    endfunction

    // Issue one request from IDLE, wait for out_valid, sample, then handshake.
    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s,
                          input logic se, input logic pre_ready, output res_t got, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        op_a = a; op_b = b; sub = s; signed_en = se; out_ready = pre_ready; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got.res = result; got.c = cout; got.n = negative_flag; got.o = overflow_flag; got.z = zero_flag;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
        check("result_held_after_hs", 64'(result), 64'(got.res));
    endtask

    task automatic cmp_res(input string tag, input res_t got, input res_t e);
        check({tag, ".result"}, 64'(got.res), 64'(e.res));
        check({tag, ".flags"}, 64'({got.c, got.n, got.o, got.z}), 64'({e.c, e.n, e.o, e.z}));
    endtask

    vec_t vecs[8];

    initial begin
        res_t          got;
        res_t          e;
        int            lat;
        int            seen;
        logic [TW-1:0] ra;
        logic [TW-1:0] rb;
        logic          rs;
        logic          rse;

        //            A             B             sub se  result        c     n     o     z
        vecs[0] = mk(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[2] = mk(32'h00000100, 32'h00000001, 1'b1, 1'b0, 32'h000000FF, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[3] = mk(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[4] = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[5] = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[6] = mk(32'h12345678, 32'h12345678, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[7] = mk(32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);

        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; signed_en = 1'b0;
        out_ready = 1'b0;
`ifdef DPA_MP_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].se, 1'b0, got, lat);
            check($sformatf("vec%0d.latency", i), 64'(lat), 64'd4);
            cmp_res($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Back-pressure: result held across RUN of the next op and through a stalled DONE.
        @(negedge clk);
        op_a = 32'h12345678; op_b = 32'h11111111; sub = 1'b0; signed_en = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp.result_unchanged_in_run", 64'(result), 64'(vecs[7].exp.res));
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp.latency", 64'(lat), 64'd4);
        op_a = 32'hAAAAAAAA; op_b = 32'h55555555; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.out_valid_held", 64'(out_valid), 64'd1);
            check("bp.in_ready_low", 64'(in_ready), 64'd0);
            check("bp.result_stable", 64'(result), 64'h23456789);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.in_ready_after_hs", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("bp.second_not_accepted", 64'(out_valid), 64'd0);
        check("bp.result_kept", 64'(result), 64'h23456789);

        // Reset while word index 2 is being processed.
        @(negedge clk);
        op_a = 32'hDEADBEEF; op_b = 32'h01010101; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, got, lat);
        check("post_reset.latency", 64'(lat), 64'd4);
        cmp_res("post_reset", got, model(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0));

`ifdef DPA_MP_ABORT_EN
        // Abort in RUN: no result, registers cleared, next request completes.
        @(negedge clk);
        op_a = 32'h11223344; op_b = 32'h01020304; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_run.result_cleared", 64'(result), 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_run.no_out_valid", 64'(seen), 64'd0);
        check("abort_run.in_ready", 64'(in_ready), 64'd1);
        run_op(32'h00FF00FF, 32'h00010001, 1'b1, 1'b1, 1'b0, got, lat);
        check("after_abort.latency", 64'(lat), 64'd4);
        cmp_res("after_abort", got, model(32'h00FF00FF, 32'h00010001, 1'b1, 1'b1));

        // Abort in DONE outranks out_ready and clears the result.
        @(negedge clk);
        op_a = 32'h0F0F0F0F; op_b = 32'h01010101; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("abort_done.latency", 64'(lat), 64'd4);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        check("abort_done.out_valid", 64'(out_valid), 64'd0);
        check("abort_done.result_cleared", 64'(result), 64'd0);
`endif

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'hFFFFFFFF;
                1: rb = ra;
                2: ra = 32'h80000000;
                3: rb = 32'h7FFFFFFF;
                default: ;
            endcase
            rs  = 1'($urandom_range(0, 1));
            rse = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, rse, 1'($urandom_range(0, 1)), got, lat);
            e = model(ra, rb, rs, rse);
            check($sformatf("rnd%0d.latency", i), 64'(lat), 64'd4);
            cmp_res($sformatf("rnd%0d", i), got, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
